// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pctl_state_t;

    localparam int unsigned FWD_NONE = 0;

    // Width of a forwarding select able to name regfile (0) or stages 1..fwd_stg.
    function automatic int unsigned fwd_sel_w(input int unsigned fwd_stg);
        return (fwd_stg < 2) ? 1 : $clog2(fwd_stg + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Forwarding select: youngest producer stage whose destination matches the source register.
module fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREG    = 32,
    parameter int unsigned FWD_STG = 2,
    localparam int unsigned RW = $clog2(NREG),
    localparam int unsigned SW = fwd_sel_w(FWD_STG)
) (
    input  logic [RW-1:0]         src,
    input  logic [FWD_STG-1:0]    stg_valid,
    input  logic [FWD_STG-1:0]    stg_we,
    input  logic                  ex_load,
    input  logic [FWD_STG*RW-1:0] stg_rd,
    output logic [SW-1:0]         sel_c
);

    logic [FWD_STG-1:0] hit;

    always_comb begin
        for (int unsigned k = 0; k < FWD_STG; k++) begin
            hit[k] = stg_valid[k] && stg_we[k] && (stg_rd[k*RW +: RW] == src);
        end
        // Load data does not exist yet while the load sits in EX.
        hit[0] = hit[0] && !ex_load;

        sel_c = SW'(FWD_NONE);
        if (src != '0) begin
            for (int k = FWD_STG - 1; k >= 0; k--) begin
                if (hit[k]) begin
                    sel_c = SW'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: stage enables/flushes, load-use stall, forwarding,
// cache-miss freeze, branch redirect and syscall halt-drain.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREG    = 32,
    parameter int unsigned FWD_STG = 2,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned RW = $clog2(NREG),
    localparam int unsigned SW = fwd_sel_w(FWD_STG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RW-1:0]         id_rs,
    input  logic [RW-1:0]         id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_halt,
    input  logic [FWD_STG-1:0]    stg_valid,
    input  logic [FWD_STG-1:0]    stg_we,
    input  logic [FWD_STG-1:0]    stg_load,
    input  logic [FWD_STG*RW-1:0] stg_rd,
    input  logic                  br_taken,
    input  logic                  mem_req,
    input  logic                  cache_done,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [SW-1:0]         fwd_rs,
    output logic [SW-1:0]         fwd_rt,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int unsigned     DW         = $clog2(FWD_STG + 2);
    localparam logic [DW-1:0]   DRAIN_INIT = DW'(FWD_STG + 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(1);

    pctl_state_t   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          wait_drain_q, wait_drain_d;
    logic [RW-1:0] ex_rd;
    logic          freeze, load_use;
    logic          run_adv, drain_adv;

    fwd_match #(.NREG(NREG), .FWD_STG(FWD_STG)) u_fwd_rs (
        .src       (id_rs),
        .stg_valid (stg_valid),
        .stg_we    (stg_we),
        .ex_load   (stg_load[0]),
        .stg_rd    (stg_rd),
        .sel_c     (fwd_rs)
    );

    fwd_match #(.NREG(NREG), .FWD_STG(FWD_STG)) u_fwd_rt (
        .src       (id_rt),
        .stg_valid (stg_valid),
        .stg_we    (stg_we),
        .ex_load   (stg_load[0]),
        .stg_rd    (stg_rd),
        .sel_c     (fwd_rt)
    );

    // Older-stage load flags carry no hazard information: their data is forwardable.
    generate
        if (FWD_STG > 1) begin : g_old_load
            logic old_load_unused;
            assign old_load_unused = ^stg_load[FWD_STG-1:1];
        end
    endgenerate

    assign ex_rd    = stg_rd[RW-1:0];
    assign freeze   = mem_req && !cache_done;
    assign load_use = id_valid && stg_valid[0] && stg_load[0] && stg_we[0] && (ex_rd != '0)
                      && ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    // Next state and stage control; a miss release replays the mode that was frozen.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        wait_drain_d = wait_drain_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        run_adv      = 1'b0;
        drain_adv    = 1'b0;

        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d      = MEM_WAIT;
                    wait_drain_d = 1'b0;
                end else begin
                    run_adv = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cache_done) begin
                    run_adv   = !wait_drain_q;
                    drain_adv = wait_drain_q;
                end
            end
            DRAIN: begin
                if (freeze) begin
                    state_d      = MEM_WAIT;
                    wait_drain_d = 1'b1;
                end else begin
                    drain_adv = 1'b1;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        if (!run_adv && !drain_adv) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end

        if (run_adv) begin
            state_d = RUN;
            if (br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_halt && id_valid) begin
                state_d = DRAIN;
                drain_d = DRAIN_INIT;
            end
        end

        // Branches are ignored here: everything younger than the syscall is squashed.
        if (drain_adv) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            drain_d     = drain_q - DRAIN_LAST;
            state_d     = (drain_q == DRAIN_LAST) ? HALTED : DRAIN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            drain_q      <= '0;
            wait_drain_q <= 1'b0;
            halted       <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            wait_drain_q <= wait_drain_d;
            halted       <= (state_d == HALTED);
            if (!pc_en && (state_q != HALTED) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl in three parameterizations.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_halt, br_taken, mem_req, cache_done;
    logic [4:0] id_rs, id_rt, s_rd1, s_rd2, s_rd3;
    logic [2:0] s_valid, s_we, s_load;

    logic [4:0]  a_en, b_en, c_en;
    logic [1:0]  a_fl, b_fl, c_fl;
    logic [1:0]  a_frs, a_frt, b_frs, b_frt, c_frs, c_frt;
    logic        a_halted, b_halted, c_halted;
    logic [15:0] a_stall, b_stall;
    logic [3:0]  c_stall;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit halted;
        bit waiting;
        bit draining;
        int left;
        int stall;
    } mdl_t;

    mdl_t ma, mb, mc;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NREG(32), .FWD_STG(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt),
        .stg_valid(s_valid[1:0]), .stg_we(s_we[1:0]), .stg_load(s_load[1:0]),
        .stg_rd({s_rd2, s_rd1}), .br_taken(br_taken), .mem_req(mem_req), .cache_done(cache_done),
        .pc_en(a_en[4]), .if_id_en(a_en[3]), .id_ex_en(a_en[2]), .ex_mem_en(a_en[1]),
        .mem_wb_en(a_en[0]), .if_id_flush(a_fl[1]), .id_ex_flush(a_fl[0]),
        .fwd_rs(a_frs), .fwd_rt(a_frt), .halted(a_halted), .stall_cnt(a_stall)
    );

    pipe_hazard_ctrl #(.NREG(16), .FWD_STG(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs[3:0]), .id_rt(id_rt[3:0]),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt),
        .stg_valid(s_valid), .stg_we(s_we), .stg_load(s_load),
        .stg_rd({s_rd3[3:0], s_rd2[3:0], s_rd1[3:0]}), .br_taken(br_taken), .mem_req(mem_req),
        .cache_done(cache_done),
        .pc_en(b_en[4]), .if_id_en(b_en[3]), .id_ex_en(b_en[2]), .ex_mem_en(b_en[1]),
        .mem_wb_en(b_en[0]), .if_id_flush(b_fl[1]), .id_ex_flush(b_fl[0]),
        .fwd_rs(b_frs), .fwd_rt(b_frt), .halted(b_halted), .stall_cnt(b_stall)
    );

    pipe_hazard_ctrl #(.NREG(32), .FWD_STG(2), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt),
        .stg_valid(s_valid[1:0]), .stg_we(s_we[1:0]), .stg_load(s_load[1:0]),
        .stg_rd({s_rd2, s_rd1}), .br_taken(br_taken), .mem_req(mem_req), .cache_done(cache_done),
        .pc_en(c_en[4]), .if_id_en(c_en[3]), .id_ex_en(c_en[2]), .ex_mem_en(c_en[1]),
        .mem_wb_en(c_en[0]), .if_id_flush(c_fl[1]), .id_ex_flush(c_fl[0]),
        .fwd_rs(c_frs), .fwd_rt(c_frt), .halted(c_halted), .stall_cnt(c_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_halt = 0;
        br_taken = 0; mem_req = 0; cache_done = 0;
        id_rs = 0; id_rt = 0; s_rd1 = 0; s_rd2 = 0; s_rd3 = 0;
        s_valid = 0; s_we = 0; s_load = 0;
    endtask

    function automatic mdl_t mdl_init();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic int stage_rd(input int k);
        case (k)
            1:       return int'(s_rd1);
            2:       return int'(s_rd2);
            default: return int'(s_rd3);
        endcase
    endfunction

    // Oldest-first is irrelevant: the first matching stage walking outward from EX wins.
    function automatic int ref_fwd(input int src, input int nstg, input int mask);
        if (src == 0) return 0;
        for (int k = 1; k <= nstg; k++) begin
            if (s_valid[k-1] && s_we[k-1] && !(k == 1 && s_load[0]) && ((stage_rd(k) & mask) == src))
                return k;
        end
        return 0;
    endfunction

    task automatic model_step(input int nstg, input int rw, input int cmax, inout mdl_t m,
                              output logic [4:0] en, output logic [1:0] fl,
                              output int frs, output int frt);
        int mask, rs, rt, rd1;
        bit lu, frozen, was_halted;
        mask = (1 << rw) - 1;
        rs   = int'(id_rs) & mask;
        rt   = int'(id_rt) & mask;
        rd1  = int'(s_rd1) & mask;
        frs  = ref_fwd(rs, nstg, mask);
        frt  = ref_fwd(rt, nstg, mask);
        lu   = id_valid && s_valid[0] && s_we[0] && s_load[0] && (rd1 != 0)
               && ((id_use_rs && rs == rd1) || (id_use_rt && rt == rd1));
        frozen     = m.waiting ? !cache_done : (mem_req && !cache_done);
        was_halted = m.halted;
        en = 5'b11111;
        fl = 2'b00;
        if (m.halted || frozen) begin
            en        = 5'b00000;
            m.waiting = !m.halted;
        end else begin
            m.waiting = 0;
            if (m.draining) begin
                en = 5'b01111;
                fl = 2'b10;
                m.left--;
                if (m.left == 0) begin
                    m.draining = 0;
                    m.halted   = 1;
                end
            end else if (br_taken) begin
                fl = 2'b11;
            end else if (lu) begin
                en = 5'b00111;
                fl = 2'b01;
            end else if (id_halt && id_valid) begin
                m.draining = 1;
                m.left     = nstg + 1;
            end
        end
        if (!en[4] && !was_halted && m.stall < cmax) m.stall++;
    endtask

    task automatic check_one(input string tag, input int nstg, input int rw, input int cmax,
                             inout mdl_t m, input logic [4:0] en_o, input logic [1:0] fl_o,
                             input logic [1:0] frs_o, input logic [1:0] frt_o,
                             input logic hal_o, input int stall_o);
        logic [4:0] en;
        logic [1:0] fl;
        int frs, frt;
        chk({tag, " halted"}, 32'(hal_o), 32'(m.halted));
        chk({tag, " stall"}, 32'(stall_o), 32'(m.stall));
        model_step(nstg, rw, cmax, m, en, fl, frs, frt);
        chk({tag, " en"}, 32'(en_o), 32'(en));
        chk({tag, " flush"}, 32'(fl_o), 32'(fl));
        chk({tag, " fwd_rs"}, 32'(frs_o), frs);
        chk({tag, " fwd_rt"}, 32'(frt_o), frt);
    endtask

    initial begin
        reset = 1;
        idle();
        #2;
        chk("reset en", 32'(a_en), 'h1f);
        chk("reset flush", 32'(a_fl), 0);
        chk("reset halted", 32'(a_halted), 0);
        chk("reset stall", 32'(a_stall), 0);
        reset = 0;

        // Forwarding priority and $0 exclusion
        id_valid = 1; id_rs = 3; id_rt = 3; id_use_rs = 1;
        s_valid = 3'b011; s_we = 3'b011; s_rd1 = 3; s_rd2 = 3;
        #1;
        chk("fwd youngest rs", 32'(a_frs), 1);
        chk("fwd youngest rt", 32'(a_frt), 1);
        s_valid = 3'b010;
        #1;
        chk("fwd stage2 only", 32'(a_frs), 2);
        s_valid = 3'b011; s_we = 3'b010;
        #1;
        chk("fwd ex not writing", 32'(a_frs), 2);
        id_rs = 0; id_rt = 0; s_rd1 = 0; s_rd2 = 0; s_we = 3'b011;
        #1;
        chk("fwd r0", 32'(a_frs), 0);
        chk("fwd r0 en", 32'(a_en), 'h1f);

        // Load-use stall
        tick(); idle();
        id_valid = 1; id_rs = 1; id_use_rs = 1; id_rt = 5; id_use_rt = 1;
        s_valid = 3'b001; s_we = 3'b001; s_load = 3'b001; s_rd1 = 5;
        #1;
        chk("lu en", 32'(a_en), 'b00111);
        chk("lu flush", 32'(a_fl), 'b01);
        chk("lu no fwd from load", 32'(a_frt), 0);
        tick();
        s_valid = 3'b010; s_we = 3'b010; s_load = 3'b010; s_rd1 = 0; s_rd2 = 5;
        #1;
        chk("lu after en", 32'(a_en), 'h1f);
        chk("lu after flush", 32'(a_fl), 0);
        chk("lu after fwd_rt", 32'(a_frt), 2);
        chk("lu stall", 32'(a_stall), 1);

        // Four-cycle cache miss
        tick(); idle();
        mem_req = 1; cache_done = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("miss en", 32'(a_en), 0);
            chk("miss flush", 32'(a_fl), 0);
            tick();
        end
        cache_done = 1;
        #1;
        chk("miss release en", 32'(a_en), 'h1f);
        tick();
        chk("miss stall", 32'(a_stall), 5);

        // Branch beats load-use and squashes a halt in ID
        idle();
        id_valid = 1; id_rt = 5; id_use_rt = 1; id_halt = 1; br_taken = 1;
        s_valid = 3'b001; s_we = 3'b001; s_load = 3'b001; s_rd1 = 5;
        #1;
        chk("br+lu en", 32'(a_en), 'h1f);
        chk("br+lu flush", 32'(a_fl), 'b11);
        tick(); idle();
        #1;
        chk("br squash halt en", 32'(a_en), 'h1f);
        chk("br stall", 32'(a_stall), 5);

        // Reset while waiting on a miss
        tick();
        mem_req = 1; cache_done = 0;
        #1;
        chk("wait entry en", 32'(a_en), 0);
        tick();
        chk("wait en", 32'(a_en), 0);
        reset = 1; mem_req = 0;
        #1;
        chk("mid reset en", 32'(a_en), 'h1f);
        chk("mid reset halted", 32'(a_halted), 0);
        chk("mid reset stall", 32'(a_stall), 0);
        reset = 0;

        // Syscall drain without misses
        tick(); idle();
        id_valid = 1; id_halt = 1;
        #1;
        chk("halt cycle en", 32'(a_en), 'h1f);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain en", 32'(a_en), 'b01111);
            chk("drain flush", 32'(a_fl), 'b10);
            chk("drain halted", 32'(a_halted), 0);
            tick();
        end
        chk("halted", 32'(a_halted), 1);
        chk("halted en", 32'(a_en), 0);
        tick();
        chk("halt stall", 32'(a_stall), 3);

        // Syscall drain with a two-cycle miss after the first drain cycle
        reset = 1; #1; reset = 0;
        idle(); id_valid = 1; id_halt = 1;
        tick(); idle();
        #1;
        chk("drain2 d1 en", 32'(a_en), 'b01111);
        tick();
        mem_req = 1; cache_done = 0;
        #1;
        chk("drain2 miss en", 32'(a_en), 0);
        tick();
        chk("drain2 wait en", 32'(a_en), 0);
        tick();
        cache_done = 1;
        #1;
        chk("drain2 release en", 32'(a_en), 'b01111);
        chk("drain2 release flush", 32'(a_fl), 'b10);
        tick(); idle();
        #1;
        chk("drain2 last en", 32'(a_en), 'b01111);
        chk("drain2 not yet", 32'(a_halted), 0);
        tick();
        chk("drain2 halted", 32'(a_halted), 1);

        // Counter saturation on the narrow instance
        reset = 1; #1; reset = 0;
        idle(); mem_req = 1; cache_done = 0;
        repeat (20) tick();
        chk("stall 20", 32'(a_stall), 20);
        chk("stall saturate", 32'(c_stall), 15);

        // Deeper pipeline, smaller register file
        reset = 1; #1; reset = 0;
        idle();
        id_valid = 1; id_rs = 3; id_use_rs = 1;
        s_valid = 3'b011; s_we = 3'b011; s_rd1 = 3; s_rd2 = 3;
        #1;
        chk("B fwd youngest", 32'(b_frs), 1);
        s_valid = 3'b100; s_we = 3'b100; s_rd3 = 3;
        #1;
        chk("B fwd stage3", 32'(b_frs), 3);
        id_rs = 19;
        #1;
        chk("B fwd rw mask", 32'(b_frs), 3);
        id_rs = 0; s_rd1 = 0; s_rd2 = 0; s_rd3 = 0; s_valid = 3'b111; s_we = 3'b111;
        #1;
        chk("B fwd r0", 32'(b_frs), 0);
        tick(); idle();
        id_valid = 1; id_halt = 1;
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("B drain en", 32'(b_en), 'b01111);
            chk("B drain halted", 32'(b_halted), 0);
            tick();
        end
        chk("B halted", 32'(b_halted), 1);

        // Randomized run against the reference model
        reset = 1; #1; reset = 0;
        ma = mdl_init(); mb = mdl_init(); mc = mdl_init();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((ma.halted && mb.halted) || $urandom_range(0, 99) == 0) begin
                reset = 1; #1; reset = 0;
                ma = mdl_init(); mb = mdl_init(); mc = mdl_init();
            end
            id_valid   = ($urandom_range(0, 7) != 0);
            id_rs      = 5'($urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 16 : 0));
            id_rt      = 5'($urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 16 : 0));
            id_use_rs  = 1'($urandom_range(0, 1));
            id_use_rt  = 1'($urandom_range(0, 1));
            id_halt    = ($urandom_range(0, 29) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            mem_req    = ($urandom_range(0, 3) == 0);
            cache_done = 1'($urandom_range(0, 1));
            s_valid    = 3'($urandom);
            s_we       = 3'($urandom);
            s_load     = 3'($urandom);
            s_rd1      = 5'($urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 16 : 0));
            s_rd2      = 5'($urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 16 : 0));
            s_rd3      = 5'($urandom_range(0, 7) + (($urandom_range(0, 3) == 0) ? 16 : 0));
            #1;
            check_one("rnd A", 2, 5, 65535, ma, a_en, a_fl, a_frs, a_frt, a_halted, int'(a_stall));
            check_one("rnd B", 3, 4, 65535, mb, b_en, b_fl, b_frs, b_frt, b_halted, int'(b_stall));
            check_one("rnd C", 2, 5, 15, mc, c_en, c_fl, c_frs, c_frt, c_halted, int'(c_stall));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
